// File: rtl/waxwing_debug_capture.sv
// waxwing_debug_capture: samples the waxwing CPU debug bus into a record FIFO and streams each
// record off-chip as a framed 8N1 UART byte sequence. Define WAXWING_DBG_TIMESTAMP_EN to append a cycle stamp.
module waxwing_debug_capture #(
  parameter int         DEPTH        = 16,
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      capture_en,
  input  logic                      clear_overflow,
  input  logic                      debug_enable,
  input  logic [2:0]                debug_state,
  input  logic [7:0]                debug_opcode,
  input  logic [7:0]                debug_mode,
  input  logic [7:0]                debug_reg0,
  input  logic [7:0]                debug_reg1,
  input  logic [31:0]               debug_raw2,
  output logic                      tx,
  output logic                      busy,
  output logic                      overflow,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef WAXWING_DBG_TIMESTAMP_EN
  localparam int TSW    = 16;
  localparam int NBYTES = 12;
`else
  localparam int TSW    = 0;
  localparam int NBYTES = 10;
`endif
  localparam int RW = 67 + TSW;

  localparam logic [AW:0]   DEPTH_C     = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO    = (AW+1)'(0);
  localparam logic [AW:0]   CNT_ONE     = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE     = AW'(1);
  localparam logic [CW-1:0] CLK_ZERO    = CW'(0);
  localparam logic [CW-1:0] CLK_ONE     = CW'(1);
  localparam logic [CW-1:0] BIT_LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_PRELAST = CW'(CLKS_PER_BIT - 2);
  localparam logic [3:0]    BYTE_LAST   = 4'(NBYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  logic [1:0]    rst_sync_r;
  logic          rst_n_s;

  logic [RW-1:0] rec_in_s;
  logic [RW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [AW:0]   count_next_s;
  logic          push_req_s;
  logic          push_ok_s;
  logic          drop_s;
  logic          pop_s;

  state_t        state_r;
  state_t        state_next_s;
  logic [CW-1:0] clk_cnt_r;
  logic [CW-1:0] clk_cnt_next_s;
  logic [2:0]    bit_idx_r;
  logic [2:0]    bit_idx_next_s;
  logic [3:0]    byte_idx_r;
  logic [3:0]    byte_idx_next_s;
  logic          bit_end_s;
  logic          last_byte_s;
  logic          fifo_has_s;

  logic [RW-1:0] frame_r;
  logic [7:0]    cur_byte_s;
  logic          tx_next_s;
  logic          busy_next_s;
  logic          tx_r;
  logic          busy_r;
  logic          overflow_r;

  // Reset synchronizer: assertion is immediate, release is aligned to Clk two edges later.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

`ifdef WAXWING_DBG_TIMESTAMP_EN
  logic [15:0] ts_r;

  // Free-running cycle stamp, wraps from 16'hFFFF to zero.
  always_ff @(posedge Clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      ts_r <= 16'h0000;
    end else begin
      ts_r <= ts_r + 16'h0001;
    end
  end

  assign rec_in_s = {debug_state, debug_opcode, debug_mode, debug_reg0, debug_reg1, debug_raw2, ts_r};
`else
  assign rec_in_s = {debug_state, debug_opcode, debug_mode, debug_reg0, debug_reg1, debug_raw2};
`endif

  // Byte k of the outgoing frame; record fields are packed MSB-first in frame order.
  function automatic logic [7:0] frame_byte(input logic [RW-1:0] rec, input logic [3:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      4'd0:    b = SYNC_BYTE;
      4'd1:    b = {5'b00000, rec[RW-1 -: 3]};
      4'd2:    b = rec[RW-4 -: 8];
      4'd3:    b = rec[RW-12 -: 8];
      4'd4:    b = rec[RW-20 -: 8];
      4'd5:    b = rec[RW-28 -: 8];
      4'd6:    b = rec[RW-36 -: 8];
      4'd7:    b = rec[RW-44 -: 8];
      4'd8:    b = rec[RW-52 -: 8];
      4'd9:    b = rec[RW-60 -: 8];
`ifdef WAXWING_DBG_TIMESTAMP_EN
      4'd10:   b = rec[15:8];
      4'd11:   b = rec[7:0];
`endif
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  assign push_req_s = capture_en & debug_enable;
  assign push_ok_s  = push_req_s & ((count_r < DEPTH_C) | pop_s);
  assign drop_s     = push_req_s & ~push_ok_s;
  assign pop_s      = (state_next_s == ST_LOAD);
  assign fifo_has_s = (count_r != CNT_ZERO);

  // FIFO occupancy after this edge.
  always_comb begin
    count_next_s = count_r;
    if (push_ok_s && !pop_s) begin
      count_next_s = count_r + CNT_ONE;
    end else if (pop_s && !push_ok_s) begin
      count_next_s = count_r - CNT_ONE;
    end else begin
      count_next_s = count_r;
    end
  end

  // Record storage; contents need no reset since occupancy is tracked by the pointers.
  always_ff @(posedge Clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= rec_in_s;
    end
  end

  // FIFO pointers, occupancy, overflow flag and the frame being serialized.
  always_ff @(posedge Clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= CNT_ZERO;
      overflow_r <= 1'b0;
      frame_r    <= {RW{1'b0}};
    end else begin
      count_r <= count_next_s;
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
        frame_r  <= mem_r[rd_ptr_r];
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clear_overflow) begin
        overflow_r <= 1'b0;
      end
    end
  end

  assign bit_end_s   = (clk_cnt_r == BIT_LAST);
  assign last_byte_s = (byte_idx_r == BYTE_LAST);

  // Serializer state register.
  always_ff @(posedge Clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r    <= ST_IDLE;
      clk_cnt_r  <= CLK_ZERO;
      bit_idx_r  <= 3'd0;
      byte_idx_r <= 4'd0;
    end else begin
      state_r    <= state_next_s;
      clk_cnt_r  <= clk_cnt_next_s;
      bit_idx_r  <= bit_idx_next_s;
      byte_idx_r <= byte_idx_next_s;
    end
  end

  // Serializer next state. A follow-on frame is popped one cycle before the final stop bit ends,
  // so the LOAD cycle supplies the last stop-bit cycle and frames stay back-to-back.
  always_comb begin
    state_next_s    = state_r;
    clk_cnt_next_s  = clk_cnt_r;
    bit_idx_next_s  = bit_idx_r;
    byte_idx_next_s = byte_idx_r;
    case (state_r)
      ST_IDLE: begin
        clk_cnt_next_s = CLK_ZERO;
        if (fifo_has_s) begin
          state_next_s    = ST_LOAD;
          byte_idx_next_s = 4'd0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_next_s   = ST_START;
        clk_cnt_next_s = CLK_ZERO;
      end
      ST_START: begin
        if (bit_end_s) begin
          state_next_s   = ST_DATA;
          clk_cnt_next_s = CLK_ZERO;
          bit_idx_next_s = 3'd0;
        end else begin
          clk_cnt_next_s = clk_cnt_r + CLK_ONE;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          clk_cnt_next_s = CLK_ZERO;
          if (bit_idx_r == 3'd7) begin
            state_next_s = ST_STOP;
          end else begin
            bit_idx_next_s = bit_idx_r + 3'd1;
          end
        end else begin
          clk_cnt_next_s = clk_cnt_r + CLK_ONE;
        end
      end
      ST_STOP: begin
        if (last_byte_s && (clk_cnt_r == BIT_PRELAST) && fifo_has_s) begin
          state_next_s    = ST_LOAD;
          byte_idx_next_s = 4'd0;
        end else if (bit_end_s) begin
          clk_cnt_next_s = CLK_ZERO;
          if (!last_byte_s) begin
            state_next_s    = ST_START;
            byte_idx_next_s = byte_idx_r + 4'd1;
          end else if (fifo_has_s) begin
            state_next_s    = ST_LOAD;
            byte_idx_next_s = 4'd0;
          end else begin
            state_next_s = ST_IDLE;
          end
        end else begin
          clk_cnt_next_s = clk_cnt_r + CLK_ONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Serializer outputs, computed from the next state so tx and busy can be registered.
  always_comb begin
    cur_byte_s = frame_byte(frame_r, byte_idx_r);
    case (state_next_s)
      ST_START: tx_next_s = 1'b0;
      ST_DATA:  tx_next_s = cur_byte_s[bit_idx_next_s];
      default:  tx_next_s = 1'b1;
    endcase
    busy_next_s = (state_next_s != ST_IDLE) || (count_next_s != CNT_ZERO);
  end

  // Output registers; tx idles high.
  always_ff @(posedge Clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      tx_r   <= 1'b1;
      busy_r <= 1'b0;
    end else begin
      tx_r   <= tx_next_s;
      busy_r <= busy_next_s;
    end
  end

  assign tx         = tx_r;
  assign busy       = busy_r;
  assign overflow   = overflow_r;
  assign fifo_count = count_r;

endmodule

// File: tb/tb_waxwing_debug_capture.sv
// Directed bench for waxwing_debug_capture: logs tx/busy every cycle and decodes frames from the log.
module tb_waxwing_debug_capture;
  localparam int DEPTH = 4;
  localparam int CPB   = 4;
`ifdef WAXWING_DBG_TIMESTAMP_EN
  localparam int NB = 12;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * 10 * CPB;
  localparam int LOGN  = 8192;

  logic        clk = 1'b0;
  logic        Reset_n;
  logic        capture_en;
  logic        clear_overflow;
  logic        debug_enable;
  logic [2:0]  debug_state;
  logic [7:0]  debug_opcode;
  logic [7:0]  debug_mode;
  logic [7:0]  debug_reg0;
  logic [7:0]  debug_reg1;
  logic [31:0] debug_raw2;
  logic        tx;
  logic        busy;
  logic        overflow;
  logic [2:0]  fifo_count;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic tx_log [LOGN];
  logic busy_log [LOGN];
  logic ov_log [LOGN];
  logic [2:0] fc_log [LOGN];

  typedef struct {
    logic [2:0]  st;
    logic [7:0]  op;
    logic [7:0]  md;
    logic [7:0]  r0;
    logic [7:0]  r1;
    logic [31:0] raw;
    logic [79:0] exp;
  } vec_t;

  vec_t vecs [3];
  vec_t ovv [6];

  waxwing_debug_capture #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .Clk(clk), .Reset_n(Reset_n), .capture_en(capture_en), .clear_overflow(clear_overflow),
    .debug_enable(debug_enable), .debug_state(debug_state), .debug_opcode(debug_opcode),
    .debug_mode(debug_mode), .debug_reg0(debug_reg0), .debug_reg1(debug_reg1),
    .debug_raw2(debug_raw2), .tx(tx), .busy(busy), .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log index k holds the outputs as they stand after rising edge k.
  always @(negedge clk) begin
    if (cyc < LOGN) begin
      tx_log[cyc]   <= tx;
      busy_log[cyc] <= busy;
      ov_log[cyc]   <= overflow;
      fc_log[cyc]   <= fifo_count;
    end
  end

  function automatic logic tx_at(input int i);
    if (i >= 0 && i < LOGN) return tx_log[i];
    return 1'bx;
  endfunction

  function automatic logic busy_at(input int i);
    if (i >= 0 && i < LOGN) return busy_log[i];
    return 1'bx;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    debug_state  = v.st;
    debug_opcode = v.op;
    debug_mode   = v.md;
    debug_reg0   = v.r0;
    debug_reg1   = v.r1;
    debug_raw2   = v.raw;
  endtask

  // Called just after a falling edge; returns the index of the push edge.
  task automatic push(input vec_t v, output int n);
    drive(v);
    debug_enable = 1'b1;
    @(negedge clk);
    n = cyc;
    debug_enable = 1'b0;
  endtask

  // Decodes NB bytes starting at log index fs, sampling mid-bit; checks framing and the first 10 bytes.
  task automatic check_frame(input string tag, input int fs, input logic [79:0] exp, output logic [15:0] ts);
    logic [7:0] b;
    logic [1:0] fr;
    ts = 16'h0000;
    for (int k = 0; k < NB; k++) begin
      int base;
      base = fs + k * 10 * CPB;
      fr = {tx_at(base + 9 * CPB + CPB / 2), tx_at(base + CPB / 2)};
      for (int j = 0; j < 8; j++) b[j] = tx_at(base + (j + 1) * CPB + CPB / 2);
      check($sformatf("%s framing byte %0d", tag, k), 64'(fr), 64'h2);
      if (k < 10) check($sformatf("%s byte %0d", tag, k), 64'(b), 64'(exp[8 * (9 - k) +: 8]));
      else ts = {ts[7:0], b};
    end
  endtask

  initial begin
    int n;
    int n2;
    int g0;
    logic [15:0] ts0;
    logic [15:0] ts1;
    logic [9:0]  seq_v;
    logic [39:0] got40;
    logic [39:0] exp40;
    logic        all_tx;
    logic        any_busy;
    logic [17:0] fc_seq;

    vecs[0] = '{3'd3, 8'h12, 8'h01, 8'h34, 8'h56, 32'hDEADBEEF, 80'hA5_03_12_01_34_56_DE_AD_BE_EF};
    vecs[1] = '{3'd7, 8'hFF, 8'h00, 8'hAA, 8'h55, 32'h01234567, 80'hA5_07_FF_00_AA_55_01_23_45_67};
    vecs[2] = '{3'd0, 8'h00, 8'h80, 8'h01, 8'hFE, 32'h80000001, 80'hA5_00_00_80_01_FE_80_00_00_01};
    for (int i = 0; i < 6; i++) begin
      ovv[i].st  = 3'(i);
      ovv[i].op  = 8'h10 + 8'(i);
      ovv[i].md  = 8'h20 + 8'(i);
      ovv[i].r0  = 8'h30 + 8'(i);
      ovv[i].r1  = 8'h40 + 8'(i);
      ovv[i].raw = 32'hC0DE0000 + 32'(i);
      ovv[i].exp = {8'hA5, 5'b00000, ovv[i].st, ovv[i].op, ovv[i].md, ovv[i].r0, ovv[i].r1, ovv[i].raw};
    end
    seq_v = 10'b1101001010;

    Reset_n = 1'b0; capture_en = 1'b0; clear_overflow = 1'b0; debug_enable = 1'b0;
    drive(vecs[2]);
    repeat (3) @(negedge clk);
    check("reset tx", 64'(tx), 64'h1);
    check("reset busy", 64'(busy), 64'h0);
    check("reset overflow", 64'(overflow), 64'h0);
    check("reset fifo_count", 64'(fifo_count), 64'h0);
    Reset_n = 1'b1;
    repeat (4) @(negedge clk);
    capture_en = 1'b1;

    // Single-sample frames from the vector table.
    for (int i = 0; i < 3; i++) begin
      push(vecs[i], n);
      repeat (FRAME + 6) @(negedge clk);
      check($sformatf("vec%0d start latency", i), 64'({tx_at(n + 1), tx_at(n + 2)}), 64'h2);
      check_frame($sformatf("vec%0d", i), n + 2, vecs[i].exp, ts0);
      check($sformatf("vec%0d end busy/tx", i),
            64'({busy_at(n + 1 + FRAME), busy_at(n + 2 + FRAME), tx_at(n + 2 + FRAME)}), 64'h5);
      if (i == 0) begin
        for (int t = 0; t < 40; t++) begin
          got40[t] = tx_at(n + 2 + t);
          exp40[t] = seq_v[t / CPB];
        end
        check("sync byte bit timing", 64'(got40), 64'(exp40));
      end
    end

    // Overflow: six back-to-back samples into a depth-4 FIFO.
    check("pre overflow idle", 64'({busy, overflow}), 64'h0);
    for (int i = 0; i < 6; i++) begin
      drive(ovv[i]);
      debug_enable = 1'b1;
      @(negedge clk);
      if (i == 0) n = cyc;
    end
    debug_enable = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) fc_seq[3 * i +: 3] = fc_log[n + i];
    check("overflow fifo_count trace", 64'(fc_seq), 64'({3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd1}));
    check("overflow flag trace", 64'({ov_log[n + 4], ov_log[n + 5]}), 64'h1);
    repeat (5 * FRAME + 6) @(negedge clk);
    for (int f = 0; f < 5; f++) check_frame($sformatf("ovf frame%0d", f), n + 2 + f * FRAME, ovv[f].exp, ts0);
    check("ovf exactly five frames",
          64'({busy_at(n + 1 + 5 * FRAME), busy_at(n + 2 + 5 * FRAME), tx_at(n + 2 + 5 * FRAME)}), 64'h5);
    check("overflow sticky", 64'(overflow), 64'h1);
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    check("overflow cleared", 64'(overflow), 64'h0);

    // Gate: capture disabled while the CPU qualifier toggles.
    capture_en = 1'b0;
    g0 = cyc + 1;
    for (int i = 0; i < 100; i++) begin
      debug_enable = ~debug_enable;
      @(negedge clk);
    end
    debug_enable = 1'b0;
    @(negedge clk);
    all_tx = 1'b1;
    any_busy = 1'b0;
    for (int i = g0; i < g0 + 100; i++) begin
      all_tx   = all_tx & tx_at(i);
      any_busy = any_busy | busy_at(i);
    end
    check("gate fifo_count", 64'(fifo_count), 64'h0);
    check("gate tx idle", 64'(all_tx), 64'h1);
    check("gate busy", 64'(any_busy), 64'h0);

    // Reset in the start bit of the third byte, with one record still queued.
    capture_en = 1'b1;
    push(vecs[0], n);
    push(vecs[1], n2);
    repeat (82) @(negedge clk);
    check("pre-reset tx/fifo_count", 64'({tx, fifo_count}), 64'({1'b0, 3'd1}));
    #2 Reset_n = 1'b0;
    #1;
    check("async reset tx", 64'(tx), 64'h1);
    check("async reset fifo_count", 64'(fifo_count), 64'h0);
    check("async reset busy", 64'(busy), 64'h0);
    @(negedge clk);
    Reset_n = 1'b1;
    repeat (4) @(negedge clk);
    push(vecs[1], n);
    repeat (FRAME + 6) @(negedge clk);
    check("post-reset start latency", 64'({tx_at(n + 1), tx_at(n + 2)}), 64'h2);
    check_frame("post-reset", n + 2, vecs[1].exp, ts0);
    check("post-reset end busy/tx",
          64'({busy_at(n + 1 + FRAME), busy_at(n + 2 + FRAME), tx_at(n + 2 + FRAME)}), 64'h5);

`ifdef WAXWING_DBG_TIMESTAMP_EN
    // Timestamps of two samples pushed seven edges apart.
    push(vecs[0], n);
    repeat (6) @(negedge clk);
    push(vecs[2], n2);
    repeat (2 * FRAME + 6) @(negedge clk);
    check("ts push spacing", 64'(n2 - n), 64'd7);
    check_frame("ts frame0", n + 2, vecs[0].exp, ts0);
    check_frame("ts frame1", n + 2 + FRAME, vecs[2].exp, ts1);
    check("ts delta", 64'(ts1 - ts0), 64'd7);
    check("ts end busy", 64'({busy_at(n + 1 + 2 * FRAME), busy_at(n + 2 + 2 * FRAME)}), 64'h2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/waxwing_debug_capture.md
Name: waxwing_debug_capture

Overview:
- Consumer end of the waxwing CPU debug bus: samples debug_state/opcode/mode/reg0/reg1/raw2 on every cycle with debug_enable high.
- Buffers samples in a record FIFO and streams them off-chip as framed bytes on a UART 8N1 transmitter.
- Sits beside the CPU core in the FPGA top level; tx drives a board UART pin, so traces are available without a simulator.

Parameters:
- DEPTH, 16, FIFO depth in records (power of two, min 2).
- CLKS_PER_BIT, 868, Clk cycles per UART bit (100 MHz / 115200).
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- capture_en  input  1  global capture gate.
- clear_overflow  input  1  synchronous clear of the overflow flag.
- debug_enable  input  1  sample qualifier from the CPU.
- debug_state  input  3  CPU FSM state.
- debug_opcode  input  8  current opcode.
- debug_mode  input  8  addressing mode.
- debug_reg0  input  8  operand register 0.
- debug_reg1  input  8  operand register 1.
- debug_raw2  input  32  raw instruction word.
- tx  output  1  UART serial out, idle high.
- busy  output  1  high while a frame is in flight or the FIFO is non-empty.
- overflow  output  1  sticky, set when a sample is dropped.
- fifo_count  output  $clog2(DEPTH)+1  records currently queued.

Behaviour:
- Reset (async assert, sync release): tx=1, busy=0, overflow=0, fifo_count=0, FIFO empty, FSM=IDLE. Reset mid-frame aborts the byte and returns tx high immediately.
- Push: on each rising edge with capture_en && debug_enable, one 67-bit record {state,opcode,mode,reg0,reg1,raw2} is pushed.
  - Accepted if count<DEPTH, or if a pop occurs on the same edge (count then unchanged).
  - Otherwise dropped and overflow<=1.
  - clear_overflow clears the flag. If it coincides with a drop, set wins.
- Pop: the serializer pops when in IDLE with the FIFO non-empty. It loads the frame register on that edge.
- Frame: 10 bytes, in order:
  - SYNC_BYTE
  - {5'b0,state}
  - opcode
  - mode
  - reg0
  - reg1
  - raw2[31:24], raw2[23:16], raw2[15:8], raw2[7:0]
- UART: each byte is 8N1 at CLKS_PER_BIT cycles per bit: start=0, data LSB first, stop=1.
  - Bytes within a frame are back-to-back, with no idle between stop and next start.
  - Consecutive frames are also back-to-back when the FIFO is non-empty at the end of the stop bit.
- FSM states: IDLE -> LOAD (pop, byte_idx=0) -> START -> DATA (8 bits) -> STOP.
  - STOP -> START: when byte_idx < last.
  - STOP -> LOAD: when the frame is done and the FIFO is non-empty.
  - STOP -> IDLE: otherwise.
- Latency: record pushed at edge N into an idle, empty block → popped at edge N+1 → tx low from edge N+2.
- Frame duration: 10*10*CLKS_PER_BIT cycles.
- busy = (FSM!=IDLE) || (count!=0).
- Simultaneous push into empty FIFO while IDLE: the record is pushed. It is not bypassed to the serializer.

Optional Feature:
- Macro: WAXWING_DBG_TIMESTAMP_EN.
- When defined:
  - A 16-bit free-running cycle counter is added; it resets to 0 and wraps at 16'hFFFF→0.
  - Its value at the push edge is stored with each record.
  - Two bytes ts[15:8], ts[7:0] are appended after raw2, giving a 12-byte frame.
- When undefined: no counter, 10-byte frames as above.

Test Plan:
- Single sample (CLKS_PER_BIT=4) with state=3, opcode=0x12, mode=0x01, reg0=0x34, reg1=0x56, raw2=0xDEADBEEF:
  - tx decodes to A5 03 12 01 34 56 DE AD BE EF.
  - Start bit begins 2 cycles after the push edge.
  - Frame lasts 400 cycles, then tx=1 and busy=0.
- Bit timing: byte 0xA5 at CLKS_PER_BIT=4 → tx held 4 cycles per bit with sequence 0,1,0,1,0,0,1,0,1,1.
- Overflow (DEPTH=4): 6 consecutive cycles of debug_enable=1 from idle:
  - Records 1–5 accepted, record 6 dropped, overflow=1.
  - Exactly 5 frames emitted back-to-back.
  - clear_overflow pulse → overflow=0.
- Gate: capture_en=0 with debug_enable toggling for 100 cycles → fifo_count=0, tx constantly 1, busy=0.
- Reset mid-frame: assert Reset_n=0 during the 3rd byte → tx=1 and fifo_count=0 asynchronously. After release, a new sample produces a complete, correct frame.
- With WAXWING_DBG_TIMESTAMP_EN: two samples pushed 7 cycles apart → timestamp bytes differ by exactly 7, frames are 12 bytes.
